// File: rtl/ddr3_frame_reader_pkg.sv
// Shared types and limits for the DDR3 frame reader.
// Test-read states exist only with DDR3_FRAME_READER_TEST_PORT_EN defined.
package ddr3_frame_reader_pkg;

  localparam int AVL_SIZE_W  = 7;
  localparam int MAX_BUFFERS = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CREDIT,
    DRAIN
`ifdef DDR3_FRAME_READER_TEST_PORT_EN
    ,
    TEST_ISSUE,
    TEST_WAIT
`endif
  } state_t;

endpackage

// File: rtl/ddr3_frame_reader_rr_buf_select.sv
// Round-robin search for a full buffer starting at start (optionally skipping it).
// Purely combinational, no backpressure.
module rr_buf_select
  import ddr3_frame_reader_pkg::*;
#(
  parameter int NUM_BUFFERS = 2
) (
  input  logic [NUM_BUFFERS-1:0] full,
  input  logic [2:0]             start,
  input  logic                   excl_start,
  output logic                   found,
  output logic [2:0]             idx
);

  logic [MAX_BUFFERS-1:0] full_ext;
  logic [2:0]             pos;

  assign full_ext = MAX_BUFFERS'(full);

  always_comb begin
    found = 1'b0;
    idx   = start;
    pos   = start;
    for (int k = 0; k < NUM_BUFFERS; k++) begin
      pos = 3'((int'(start) + k) % NUM_BUFFERS);
      if (!found && full_ext[pos] && !(excl_start && k == 0)) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/ddr3_frame_reader.sv
// Streams whole frames from N DDR3 frame buffers into the pixel FIFO; pix_* lag read data by 1 cycle.
// Bursts are gated by fifo_free credits and held while ddr3_avl_ready is low; optional DDR3_FRAME_READER_TEST_PORT_EN.
module ddr3_frame_reader
  import ddr3_frame_reader_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 1024,
  parameter int PIX_BITS     = 32,
  parameter int DATA_W       = 128,
  parameter int ADDR_W       = 26,
  parameter int NUM_BUFFERS  = 2,
  parameter int BURST_LEN    = 4,
  parameter int CREDIT_W     = 10
) (
  input  logic                          ddr3_clk,
  input  logic                          ddr3_reset_n,
  input  logic [NUM_BUFFERS-1:0]        buf_full,
  input  logic [NUM_BUFFERS*ADDR_W-1:0] buf_offset,
  output logic [NUM_BUFFERS-1:0]        buf_release,
  output logic [2:0]                    cur_buf,
  input  logic [CREDIT_W-1:0]           fifo_free,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          pix_valid,
  output logic                          pix_sof,
  input  logic                          ddr3_avl_ready,
  output logic                          ddr3_avl_burstbegin,
  output logic                          ddr3_avl_read_req,
  output logic [AVL_SIZE_W-1:0]         ddr3_avl_size,
  output logic [ADDR_W-1:0]             ddr3_avl_addr,
  input  logic                          ddr3_avl_read_data_valid,
`ifdef DDR3_FRAME_READER_TEST_PORT_EN
  input  logic                          test_rd,
  input  logic [ADDR_W-1:0]             test_addr,
  output logic [DATA_W-1:0]             test_rd_data,
  output logic                          test_rd_done,
`endif
  input  logic [DATA_W-1:0]             ddr3_avl_read_data
);

  localparam int FRAME_WORDS = IMAGE_WIDTH * IMAGE_HEIGHT * PIX_BITS / DATA_W;
  localparam int WC_W        = $clog2(FRAME_WORDS + 1);

  if (FRAME_WORDS % BURST_LEN != 0) begin : g_bad_frame
    $error("FRAME_WORDS must be a multiple of BURST_LEN");
  end
  if (NUM_BUFFERS < 2 || NUM_BUFFERS > MAX_BUFFERS) begin : g_bad_nbuf
    $error("NUM_BUFFERS out of range");
  end

  state_t                state;
  logic [WC_W-1:0]       word_cnt;
  logic [CREDIT_W-1:0]   outstanding;
  logic                  sof_pending;
  logic [ADDR_W-1:0]     offs [MAX_BUFFERS];
  logic                  idle_found, drain_found;
  logic [2:0]            idle_idx, drain_idx;
  logic                  credit_ok, frame_accept, frame_rdv, frame_last;

  for (genvar g = 0; g < MAX_BUFFERS; g++) begin : g_offs
    if (g < NUM_BUFFERS) begin : g_on
      assign offs[g] = buf_offset[g*ADDR_W +: ADDR_W];
    end else begin : g_off
      assign offs[g] = '0;
    end
  end

  rr_buf_select #(.NUM_BUFFERS(NUM_BUFFERS)) u_idle_sel (
    .full(buf_full), .start(cur_buf), .excl_start(1'b0), .found(idle_found), .idx(idle_idx)
  );

  rr_buf_select #(.NUM_BUFFERS(NUM_BUFFERS)) u_drain_sel (
    .full(buf_full), .start(cur_buf), .excl_start(1'b1), .found(drain_found), .idx(drain_idx)
  );

  // One extra bit so outstanding+BURST_LEN cannot wrap before the compare.
  assign credit_ok    = ({1'b0, outstanding} + (CREDIT_W+1)'(BURST_LEN)) <= {1'b0, fifo_free};
  assign frame_accept = ddr3_avl_read_req && ddr3_avl_ready && (state == ISSUE);
  assign frame_last   = (word_cnt + WC_W'(BURST_LEN)) == WC_W'(FRAME_WORDS);
`ifdef DDR3_FRAME_READER_TEST_PORT_EN
  assign frame_rdv    = ddr3_avl_read_data_valid && (state != TEST_WAIT);
`else
  assign frame_rdv    = ddr3_avl_read_data_valid;
`endif

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      state               <= IDLE;
      cur_buf             <= '0;
      word_cnt            <= '0;
      sof_pending         <= 1'b0;
      buf_release         <= '0;
      ddr3_avl_read_req   <= 1'b0;
      ddr3_avl_burstbegin <= 1'b0;
      ddr3_avl_size       <= '0;
      ddr3_avl_addr       <= '0;
`ifdef DDR3_FRAME_READER_TEST_PORT_EN
      test_rd_data        <= '0;
      test_rd_done        <= 1'b0;
`endif
    end else begin
      buf_release <= '0;
`ifdef DDR3_FRAME_READER_TEST_PORT_EN
      test_rd_done <= 1'b0;
`endif
      if (frame_rdv) sof_pending <= 1'b0;
      case (state)
        IDLE: begin
`ifdef DDR3_FRAME_READER_TEST_PORT_EN
          if (test_rd) begin
            ddr3_avl_addr       <= test_addr;
            ddr3_avl_size       <= AVL_SIZE_W'(1);
            ddr3_avl_read_req   <= 1'b1;
            ddr3_avl_burstbegin <= 1'b1;
            state               <= TEST_ISSUE;
          end else
`endif
          if (idle_found) begin
            cur_buf       <= idle_idx;
            ddr3_avl_addr <= offs[idle_idx];
            word_cnt      <= '0;
            sof_pending   <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (ddr3_avl_read_req) begin
            if (ddr3_avl_ready) begin
              ddr3_avl_read_req   <= 1'b0;
              ddr3_avl_burstbegin <= 1'b0;
              ddr3_avl_addr       <= ddr3_avl_addr + ADDR_W'(BURST_LEN);
              word_cnt            <= word_cnt + WC_W'(BURST_LEN);
              if (frame_last) state <= DRAIN;
            end
          end else if (credit_ok) begin
            ddr3_avl_read_req   <= 1'b1;
            ddr3_avl_burstbegin <= 1'b1;
            ddr3_avl_size       <= AVL_SIZE_W'(BURST_LEN);
          end else begin
            state <= WAIT_CREDIT;
          end
        end
        WAIT_CREDIT: begin
          if (credit_ok) begin
            ddr3_avl_read_req   <= 1'b1;
            ddr3_avl_burstbegin <= 1'b1;
            ddr3_avl_size       <= AVL_SIZE_W'(BURST_LEN);
            state               <= ISSUE;
          end
        end
        DRAIN: begin
          // With no other full buffer the current frame is shown again, unreleased.
          if (outstanding == '0) begin
            if (drain_found) begin
              buf_release <= NUM_BUFFERS'(1) << cur_buf;
              cur_buf     <= drain_idx;
            end
            state <= IDLE;
          end
        end
`ifdef DDR3_FRAME_READER_TEST_PORT_EN
        TEST_ISSUE: begin
          if (ddr3_avl_ready) begin
            ddr3_avl_read_req   <= 1'b0;
            ddr3_avl_burstbegin <= 1'b0;
            state               <= TEST_WAIT;
          end
        end
        TEST_WAIT: begin
          if (ddr3_avl_read_data_valid) begin
            test_rd_data <= ddr3_avl_read_data;
            test_rd_done <= 1'b1;
            state        <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      outstanding <= '0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      pix_sof     <= 1'b0;
    end else begin
      outstanding <= outstanding
                   + (frame_accept ? CREDIT_W'(BURST_LEN) : CREDIT_W'(0))
                   - (frame_rdv ? CREDIT_W'(1) : CREDIT_W'(0));
      pix_data    <= ddr3_avl_read_data;
      pix_valid   <= frame_rdv;
      pix_sof     <= frame_rdv && sof_pending;
    end
  end

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Randomised DDR3 responder plus frame-level reference for ddr3_frame_reader (4 buffers, 16-word frames).
module tb_ddr3_frame_reader;

  localparam int NB = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int FW = 16;
  localparam int BL = 4;

  logic              ddr3_clk = 1'b0;
  logic              ddr3_reset_n = 1'b0;
  logic [NB-1:0]     buf_full = '0;
  logic [NB*AW-1:0]  buf_offset = '0;
  logic [NB-1:0]     buf_release;
  logic [2:0]        cur_buf;
  logic [9:0]        fifo_free = '0;
  logic [DW-1:0]     pix_data;
  logic              pix_valid, pix_sof;
  logic              ddr3_avl_ready = 1'b0;
  logic              ddr3_avl_burstbegin, ddr3_avl_read_req;
  logic [6:0]        ddr3_avl_size;
  logic [AW-1:0]     ddr3_avl_addr;
  logic              ddr3_avl_read_data_valid = 1'b0;
  logic [DW-1:0]     ddr3_avl_read_data = '0;
`ifdef DDR3_FRAME_READER_TEST_PORT_EN
  logic              test_rd = 1'b0;
  logic [AW-1:0]     test_addr = '0;
  logic [DW-1:0]     test_rd_data;
  logic              test_rd_done;
`endif

  ddr3_frame_reader #(
    .IMAGE_WIDTH(16), .IMAGE_HEIGHT(1), .PIX_BITS(32), .DATA_W(DW), .ADDR_W(AW),
    .NUM_BUFFERS(NB), .BURST_LEN(BL), .CREDIT_W(10)
  ) dut (
    .ddr3_clk(ddr3_clk), .ddr3_reset_n(ddr3_reset_n), .buf_full(buf_full),
    .buf_offset(buf_offset), .buf_release(buf_release), .cur_buf(cur_buf),
    .fifo_free(fifo_free), .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .ddr3_avl_ready(ddr3_avl_ready), .ddr3_avl_burstbegin(ddr3_avl_burstbegin),
    .ddr3_avl_read_req(ddr3_avl_read_req), .ddr3_avl_size(ddr3_avl_size),
    .ddr3_avl_addr(ddr3_avl_addr), .ddr3_avl_read_data_valid(ddr3_avl_read_data_valid),
`ifdef DDR3_FRAME_READER_TEST_PORT_EN
    .test_rd(test_rd), .test_addr(test_addr), .test_rd_data(test_rd_data),
    .test_rd_done(test_rd_done),
`endif
    .ddr3_avl_read_data(ddr3_avl_read_data)
  );

  always #5 ddr3_clk = ~ddr3_clk;

  int             checks = 0;
  int             errors = 0;
  logic [31:0]    salt;
  logic [AW-1:0]  off [NB];
  int             ready_mode = 0;   // 0 always ready, 1 random, 2 held low
  bit             rdv_en = 1'b1;
  logic [AW-1:0]  pend[$];
  logic [DW-1:0]  pix_q[$];
  bit             sof_q[$];
  logic [AW-1:0]  acc_addr_q[$];
  logic [6:0]     acc_size_q[$];
  logic [NB-1:0]  rel_q[$];
  int             rel_at_q[$];
  int             done_cnt = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ salt;
  endfunction

  // Next buffer after a frame: first full one after cur (mod NB), else cur again.
  function automatic int next_buf(input int cur, input logic [NB-1:0] full);
    for (int d = 1; d < NB; d++)
      if (full[2'((cur + d) % NB)]) return (cur + d) % NB;
    return cur;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_words(input int n, input int budget);
    int c;
    c = 0;
    while (pix_q.size() < n && c < budget) begin
      @(negedge ddr3_clk);
      c++;
    end
    chk($sformatf("wait_words_%0d", n), 64'(pix_q.size() >= n), 64'(1));
  endtask

  task automatic clear_logs();
    pix_q.delete(); sof_q.delete(); acc_addr_q.delete(); acc_size_q.delete();
    rel_q.delete(); rel_at_q.delete();
  endtask

  // DDR3 controller model and output monitor, all on the falling edge.
  initial begin
    forever begin
      @(negedge ddr3_clk);
      if (pix_valid) begin
        pix_q.push_back(pix_data);
        sof_q.push_back(pix_sof);
      end
      if (buf_release != '0) begin
        rel_q.push_back(buf_release);
        rel_at_q.push_back(pix_q.size());
      end
`ifdef DDR3_FRAME_READER_TEST_PORT_EN
      if (test_rd_done) done_cnt++;
`endif
      if (!ddr3_reset_n) begin
        pend.delete();
        ddr3_avl_ready = 1'b0;
        ddr3_avl_read_data_valid = 1'b0;
      end else begin
        if (pend.size() > 0 && rdv_en && $urandom_range(0, 99) < 60) begin
          ddr3_avl_read_data_valid = 1'b1;
          ddr3_avl_read_data = mem_word(pend.pop_front());
        end else begin
          ddr3_avl_read_data_valid = 1'b0;
          ddr3_avl_read_data = $urandom;
        end
        case (ready_mode)
          0:       ddr3_avl_ready = 1'b1;
          1:       ddr3_avl_ready = ($urandom_range(0, 3) != 0);
          default: ddr3_avl_ready = 1'b0;
        endcase
        if (ddr3_avl_read_req && ddr3_avl_ready) begin
          acc_addr_q.push_back(ddr3_avl_addr);
          acc_size_q.push_back(ddr3_avl_size);
          for (int i = 0; i < int'(ddr3_avl_size); i++) pend.push_back(AW'(ddr3_avl_addr + AW'(i)));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    int             frames[6];
    logic [NB-1:0]  mend[5];
    logic [NB-1:0]  exp_rel[$];
    int             exp_rel_at[$];
    logic [AW-1:0]  a0;
    int             na, n0;

    salt   = $urandom;
    off[0] = AW'($urandom);
    off[1] = AW'($urandom);
    off[2] = AW'($urandom);
    off[3] = 26'h3FF_FFF8;   // bursts wrap through address 0
    buf_offset = {off[3], off[2], off[1], off[0]};

    // Reset state
    repeat (3) @(negedge ddr3_clk);
    chk("rst_read_req", 64'(ddr3_avl_read_req), 64'(0));
    chk("rst_burstbegin", 64'(ddr3_avl_burstbegin), 64'(0));
    chk("rst_size", 64'(ddr3_avl_size), 64'(0));
    chk("rst_addr", 64'(ddr3_avl_addr), 64'(0));
    chk("rst_pix_valid", 64'(pix_valid), 64'(0));
    chk("rst_pix_sof", 64'(pix_sof), 64'(0));
    chk("rst_pix_data", 64'(pix_data), 64'(0));
    chk("rst_release", 64'(buf_release), 64'(0));
    chk("rst_cur_buf", 64'(cur_buf), 64'(0));

    // Multi-frame run with random ready/data timing and buffer switches
    mend[0] = 4'b0001; mend[1] = 4'b0001; mend[2] = 4'b0011; mend[3] = 4'b1001; mend[4] = 4'b1001;
    frames[0] = 0;
    for (int f = 0; f < 5; f++) begin
      frames[f+1] = next_buf(frames[f], mend[f]);
      if (frames[f+1] != frames[f]) begin
        exp_rel.push_back(NB'(1) << frames[f]);
        exp_rel_at.push_back((f + 1) * FW);
      end
    end
    buf_full = 4'b0001; fifo_free = 10'd64; ready_mode = 1; rdv_en = 1'b1;
    ddr3_reset_n = 1'b1;
    wait_words(5, 2000);
    chk("cur_buf_f0", 64'(cur_buf), 64'(0));
    wait_words(37, 2000);
    buf_full = 4'b0011;
    wait_words(53, 2000);
    buf_full = 4'b1001;
    wait_words(69, 2000);
    chk("cur_buf_f4", 64'(cur_buf), 64'(frames[4]));
    wait_words(96, 3000);
    for (int i = 0; i < 96; i++) begin
      chk($sformatf("pix_data_%0d", i), 64'(pix_q[i]), 64'(mem_word(AW'(off[frames[i/FW]] + AW'(i % FW)))));
      chk($sformatf("pix_sof_%0d", i), 64'(sof_q[i]), 64'(i % FW == 0));
    end
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("burst_addr_%0d", k), 64'(acc_addr_q[k]),
          64'(AW'(off[frames[k/(FW/BL)]] + AW'(BL * (k % (FW/BL))))));
      chk($sformatf("burst_size_%0d", k), 64'(acc_size_q[k]), 64'(BL));
    end
    chk("release_count", 64'(rel_q.size() >= exp_rel.size()), 64'(1));
    for (int r = 0; r < exp_rel.size(); r++) begin
      chk($sformatf("release_mask_%0d", r), 64'(rel_q[r]), 64'(exp_rel[r]));
      chk($sformatf("release_at_%0d", r), 64'(rel_at_q[r]), 64'(exp_rel_at[r]));
    end

    // Reset mid-operation
    @(negedge ddr3_clk); #1;
    ddr3_reset_n = 1'b0;
    #1;
    chk("mid_rst_read_req", 64'(ddr3_avl_read_req), 64'(0));
    chk("mid_rst_pix_valid", 64'(pix_valid), 64'(0));
    chk("mid_rst_release", 64'(buf_release), 64'(0));
    chk("mid_rst_cur_buf", 64'(cur_buf), 64'(0));
    chk("mid_rst_addr", 64'(ddr3_avl_addr), 64'(0));
    repeat (2) @(negedge ddr3_clk);
    clear_logs();

    // Credit gating: one burst fits in 6 free slots, the second needs 8
    buf_full = 4'b0001; fifo_free = 10'd6; ready_mode = 0; rdv_en = 1'b0;
    #1 ddr3_reset_n = 1'b1;
    repeat (12) @(negedge ddr3_clk);
    chk("credit_bursts_6", 64'(acc_addr_q.size()), 64'(1));
    chk("credit_first_addr", 64'(acc_addr_q[0]), 64'(off[0]));
    chk("credit_read_req_idle", 64'(ddr3_avl_read_req), 64'(0));
    chk("credit_no_release", 64'(rel_q.size()), 64'(0));
    @(negedge ddr3_clk);
    ready_mode = 2; fifo_free = 10'd8;
    chk("credit_req_before", 64'(ddr3_avl_read_req), 64'(0));
    @(negedge ddr3_clk);
    chk("credit_req_next", 64'(ddr3_avl_read_req), 64'(1));
    a0 = ddr3_avl_addr;
    chk("credit_second_addr", 64'(a0), 64'(AW'(off[0] + AW'(BL))));
    for (int c = 0; c < 5; c++) begin
      @(negedge ddr3_clk);
      chk($sformatf("stall_req_%0d", c), 64'(ddr3_avl_read_req), 64'(1));
      chk($sformatf("stall_addr_%0d", c), 64'(ddr3_avl_addr), 64'(a0));
      chk($sformatf("stall_bursts_%0d", c), 64'(acc_addr_q.size()), 64'(1));
    end
    ready_mode = 0;
    repeat (6) @(negedge ddr3_clk);
    chk("stall_one_burst", 64'(acc_addr_q.size()), 64'(2));
    chk("stall_req_low", 64'(ddr3_avl_read_req), 64'(0));
    rdv_en = 1'b1; fifo_free = 10'd64; ready_mode = 1;
    wait_words(16, 2000);
    for (int i = 0; i < FW; i++) begin
      chk($sformatf("post_rst_data_%0d", i), 64'(pix_q[i]), 64'(mem_word(AW'(off[0] + AW'(i)))));
      chk($sformatf("post_rst_sof_%0d", i), 64'(sof_q[i]), 64'(i == 0));
    end

`ifdef DDR3_FRAME_READER_TEST_PORT_EN
    // Single-word test read from IDLE
    buf_full = '0;
    repeat (300) @(negedge ddr3_clk);
    chk("test_idle_req", 64'(ddr3_avl_read_req), 64'(0));
    na = acc_addr_q.size();
    n0 = pix_q.size();
    test_addr = 26'h100;
    test_rd = 1'b1;
    @(negedge ddr3_clk);
    test_rd = 1'b0;
    for (int c = 0; c < 100 && done_cnt == 0; c++) @(negedge ddr3_clk);
    repeat (3) @(negedge ddr3_clk);
    chk("test_done_pulses", 64'(done_cnt), 64'(1));
    chk("test_rd_data", 64'(test_rd_data), 64'(mem_word(26'h100)));
    chk("test_req_count", 64'(acc_addr_q.size()), 64'(na + 1));
    chk("test_req_addr", 64'(acc_addr_q[na]), 64'(26'h100));
    chk("test_req_size", 64'(acc_size_q[na]), 64'(1));
    chk("test_no_pix", 64'(pix_q.size()), 64'(n0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
